// File: rtl/read_return_engine.sv
// read_return_engine: timestamped read queue that captures critical-word-first bursts into full lines
module read_return_engine #(
   parameter int          DATA_WIDTH  = 64,
   parameter int          BURST_LEN   = 8,
   parameter int          QUEUE_DEPTH = 16,
   parameter int          TAG_BITS    = 64,
   parameter int          CAS_LATENCY = 22,
   parameter logic [31:0] CYCLE_INIT  = 32'd0
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            issue_valid_in,
   input  logic [TAG_BITS-1:0]             issue_tag_in,
   input  logic [$clog2(BURST_LEN)-1:0]    issue_col_in,
   output logic                            issue_ready_out,
   input  logic                            flush_in,
   input  logic [DATA_WIDTH-1:0]           dq_in,
   output logic                            capturing_out,
   output logic                            data_valid_out,
   output logic [TAG_BITS-1:0]             data_tag_out,
   output logic [BURST_LEN*DATA_WIDTH-1:0] data_line_out,
   output logic [$clog2(QUEUE_DEPTH):0]    count_out,
   output logic                            overflow_out,
   output logic                            timing_err_out
);
   localparam int          CW    = $clog2(BURST_LEN);
   localparam int          PW    = $clog2(QUEUE_DEPTH);
   localparam logic [31:0] CAS   = 32'(CAS_LATENCY);
   localparam logic [PW:0] DEPTH = (PW+1)'(QUEUE_DEPTH);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                          state_q, state_d;
   logic [31:0]                     cycle_q;
   logic [TAG_BITS-1:0]             tag_mem  [QUEUE_DEPTH];
   logic [CW-1:0]                   col_mem  [QUEUE_DEPTH];
   logic [31:0]                     time_mem [QUEUE_DEPTH];
   logic [PW-1:0]                   rd_q, wr_q, rd_nx;
   logic [PW:0]                     count_q;
   logic [CW-1:0]                   beat_q, beat_d, slot;
   logic [BURST_LEN*DATA_WIDTH-1:0] line_q, line_d;
   logic [31:0]                     head_age, next_age;
   logic                            full, accept, last, deq, start, late;

   // age is measured to the edge that would sample the first beat, so "due" means age >= CAS
   assign rd_nx           = rd_q + PW'(1);
   assign head_age        = cycle_q - time_mem[rd_q] + 32'd1;
   assign next_age        = cycle_q - time_mem[rd_nx] + 32'd1;
   assign full            = count_q == DEPTH;
   assign accept          = issue_valid_in && !full && !flush_in;
   assign last            = state_q == BURST && beat_q == LAST_BEAT;
   assign deq             = last && !flush_in;
   assign slot            = col_mem[rd_q] + beat_q;
   assign issue_ready_out = !full;
   assign capturing_out   = state_q == BURST;
   assign count_out       = count_q;

   // next state and beat index; a burst restarts on its own last beat when the next head is due
   always_comb begin
      state_d = state_q;
      beat_d  = '0;
      start   = 1'b0;
      late    = 1'b0;
      if (flush_in)
         state_d = IDLE;
      else if (state_q == IDLE) begin
         start   = count_q != '0 && head_age >= CAS;
         late    = head_age > CAS;
         state_d = start ? BURST : IDLE;
      end else if (last) begin
         start   = count_q > (PW+1)'(1) && next_age >= CAS;
         late    = next_age > CAS;
         state_d = start ? BURST : IDLE;
      end else
         beat_d  = beat_q + CW'(1);
   end

   // state register, beat counter and free-running timestamp counter
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         state_q <= IDLE;
         beat_q  <= '0;
         cycle_q <= CYCLE_INIT;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cycle_q <= cycle_q + 32'd1;
      end

   // queue pointers and occupancy; an entry leaves only when its last beat is sampled
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else if (flush_in) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (accept) wr_q <= wr_q + PW'(1);
         if (deq) rd_q <= rd_nx;
         count_q <= count_q + (PW+1)'(accept) - (PW+1)'(deq);
      end

   // queue storage: tag, critical beat and issue timestamp
   always_ff @(posedge clk_in)
      if (accept) begin
         tag_mem[wr_q]  <= issue_tag_in;
         col_mem[wr_q]  <= issue_col_in;
         time_mem[wr_q] <= cycle_q;
      end

   // place the current beat into its critical-word-first slot
   always_comb begin
      line_d = line_q;
      if (state_q == BURST) line_d[slot*DATA_WIDTH +: DATA_WIDTH] = dq_in;
   end

   // line assembly, completion outputs and sticky error flags
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         line_q         <= '0;
         data_valid_out <= 1'b0;
         data_tag_out   <= '0;
         data_line_out  <= '0;
         overflow_out   <= 1'b0;
         timing_err_out <= 1'b0;
      end else begin
         line_q         <= line_d;
         data_valid_out <= deq;
         if (deq) begin
            data_line_out <= line_d;
            data_tag_out  <= tag_mem[rd_q];
         end
         if (issue_valid_in && full && !flush_in) overflow_out <= 1'b1;
         if (start && late) timing_err_out <= 1'b1;
      end
endmodule

// File: tb/tb_read_return_engine.sv
// tb_read_return_engine: directed and randomized checks of the read return path against a line-level model
`timescale 1ns/1ps
module tb_read_return_engine;
   localparam int DW = 64, BL = 8, QD = 16, TW = 64, CAS = 22;

   logic              clk_in = 1'b0, rst_in = 1'b1;
   logic              issue_valid_in = 1'b0, flush_in = 1'b0;
   logic [TW-1:0]     issue_tag_in = '0;
   logic [2:0]        issue_col_in = '0;
   logic [DW-1:0]     dq_in = '0;
   logic              issue_ready_out, capturing_out, data_valid_out, overflow_out, timing_err_out;
   logic [TW-1:0]     data_tag_out;
   logic [BL*DW-1:0]  data_line_out;
   logic [4:0]        count_out;

   // model entry: issue edge, tag, critical beat, first/last beat edges, late start
   typedef struct { int t; logic [TW-1:0] tag; int col; int start; int done; bit late; } ent_t;
   typedef struct { int e; logic [TW-1:0] tag; logic [BL*DW-1:0] line; } obs_t;

   ent_t          pend[$];
   obs_t          obs[$];
   logic [DW-1:0] dq_hist [int];
   logic [DW-1:0] dq_plan [int];
   logic [DW-1:0] dq_v;
   int            edge_n = 0, last_done = -1000, checks = 0, failures = 0;
   bit            exp_ovf = 1'b0, exp_terr = 1'b0;

   // counter starts just below 2^32 so every test crosses the timestamp wrap
   read_return_engine #(.CYCLE_INIT(32'hFFFF_FFF0)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .issue_valid_in(issue_valid_in), .issue_tag_in(issue_tag_in), .issue_col_in(issue_col_in),
      .issue_ready_out(issue_ready_out), .flush_in(flush_in), .dq_in(dq_in),
      .capturing_out(capturing_out), .data_valid_out(data_valid_out), .data_tag_out(data_tag_out),
      .data_line_out(data_line_out), .count_out(count_out), .overflow_out(overflow_out),
      .timing_err_out(timing_err_out)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) edge_n <= edge_n + 1;

   // drive the bus value for the next edge, remember it, and record completed lines
   always @(negedge clk_in) begin
      dq_v = dq_plan.exists(edge_n + 1) ? dq_plan[edge_n + 1] : {$urandom, $urandom};
      dq_in = dq_v;
      dq_hist[edge_n + 1] = dq_v;
      if (data_valid_out) obs.push_back(obs_t'{edge_n, data_tag_out, data_line_out});
   end

   function automatic logic [BL*DW-1:0] line_of(ent_t x);
      logic [BL*DW-1:0] l = '0;
      for (int k = 0; k < BL; k++) l[((x.col + k) % BL)*DW +: DW] = dq_hist[x.start + k];
      return l;
   endfunction

   function automatic int occ(int e);
      int n = 0;
      foreach (pend[j]) if (pend[j].t <= e && pend[j].done > e) n++;
      return n;
   endfunction

   function automatic bit terr_model();
      bit r = exp_terr;
      foreach (pend[j]) if (pend[j].late && pend[j].start - 1 <= edge_n) r = 1'b1;
      return r;
   endfunction

   task automatic tick(int n);
      repeat (n) begin
         @(negedge clk_in);
         issue_valid_in = 1'b0;
         flush_in = 1'b0;
      end
   endtask

   task automatic wait_edge(int e);
      while (edge_n < e) begin
         @(negedge clk_in);
         issue_valid_in = 1'b0;
         flush_in = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b1;
      tick(2);
      rst_in = 1'b0;
      pend.delete();
      obs.delete();
      last_done = -1000;
      exp_ovf = 1'b0;
      exp_terr = 1'b0;
   endtask

   task automatic issue(input logic [TW-1:0] tag, input logic [2:0] col, output int t);
      ent_t x;
      @(negedge clk_in);
      flush_in = 1'b0;
      issue_valid_in = 1'b1;
      issue_tag_in = tag;
      issue_col_in = col;
      t = edge_n + 1;
      if (occ(t - 1) >= QD) exp_ovf = 1'b1;
      else begin
         x.t = t;
         x.tag = tag;
         x.col = int'(col);
         x.start = (t + CAS > last_done + 1) ? t + CAS : last_done + 1;
         x.done = x.start + BL - 1;
         x.late = x.start > t + CAS;
         last_done = x.done;
         pend.push_back(x);
      end
   endtask

   task automatic do_flush();
      ent_t keep[$];
      int f;
      @(negedge clk_in);
      issue_valid_in = 1'b0;
      flush_in = 1'b1;
      f = edge_n + 1;
      foreach (pend[j])
         if (pend[j].done < f) keep.push_back(pend[j]);
         else if (pend[j].late && pend[j].start <= f) exp_terr = 1'b1;
      pend = keep;
      last_done = -1000;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count_out); end
      checks++; if (issue_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", issue_ready_out); end
      checks++; if (capturing_out !== 1'b0) begin failures++; $display("FAIL reset_capturing: got %b expected 0", capturing_out); end
      checks++; if (data_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", data_valid_out); end
      checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow_out); end
      checks++; if (timing_err_out !== 1'b0) begin failures++; $display("FAIL reset_timing_err: got %b expected 0", timing_err_out); end
      checks++; if (data_tag_out !== '0) begin failures++; $display("FAIL reset_tag: got %h expected 0", data_tag_out); end
      checks++; if (data_line_out !== '0) begin failures++; $display("FAIL reset_line: got %h expected 0", data_line_out); end
   endtask

   task automatic test_single();
      int t;
      do_reset();
      tick(2);
      issue(64'h1000, 3'd0, t);
      for (int k = 0; k < BL; k++) dq_plan[t + CAS + k] = 64'(k + 1);
      tick(1);
      checks++; if (count_out !== 5'd1) begin failures++; $display("FAIL single_count1: got %0d expected 1", count_out); end
      wait_edge(t + CAS + BL - 1);
      checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL single_count0: got %0d expected 0", count_out); end
      tick(1);
      checks++;
      if (obs.size() != 1) begin failures++; $display("FAIL single_lines: got %0d expected 1", obs.size()); end
      else begin
         checks++; if (obs[0].e !== t + CAS + BL - 1) begin failures++; $display("FAIL single_edge: got %0d expected %0d", obs[0].e, t + CAS + BL - 1); end
         checks++; if (obs[0].tag !== 64'h1000) begin failures++; $display("FAIL single_tag: got %h expected 1000", obs[0].tag); end
         for (int k = 0; k < BL; k++) begin
            checks++;
            if (obs[0].line[k*DW +: DW] !== 64'(k + 1)) begin failures++; $display("FAIL single_slot%0d: got %h expected %h", k, obs[0].line[k*DW +: DW], 64'(k + 1)); end
         end
      end
   endtask

   task automatic test_wrap();
      int t;
      do_reset();
      tick(1);
      issue(64'hBEEF, 3'd5, t);
      for (int k = 0; k < BL; k++) dq_plan[t + CAS + k] = 64'hA0 + 64'(k);
      wait_edge(t + CAS - 2);
      checks++; if (capturing_out !== 1'b0) begin failures++; $display("FAIL wrap_cap_early: got %b expected 0", capturing_out); end
      tick(1);
      checks++; if (capturing_out !== 1'b1) begin failures++; $display("FAIL wrap_cap_start: got %b expected 1", capturing_out); end
      wait_edge(t + CAS + BL - 2);
      checks++; if (capturing_out !== 1'b1) begin failures++; $display("FAIL wrap_cap_last: got %b expected 1", capturing_out); end
      tick(1);
      checks++; if (capturing_out !== 1'b0) begin failures++; $display("FAIL wrap_cap_end: got %b expected 0", capturing_out); end
      checks++; if (data_valid_out !== 1'b1) begin failures++; $display("FAIL wrap_valid: got %b expected 1", data_valid_out); end
      checks++; if (data_tag_out !== 64'hBEEF) begin failures++; $display("FAIL wrap_tag: got %h expected beef", data_tag_out); end
      checks++; if (data_line_out[5*DW +: DW] !== 64'hA0) begin failures++; $display("FAIL wrap_slot5: got %h expected a0", data_line_out[5*DW +: DW]); end
      checks++; if (data_line_out[7*DW +: DW] !== 64'hA2) begin failures++; $display("FAIL wrap_slot7: got %h expected a2", data_line_out[7*DW +: DW]); end
      checks++; if (data_line_out[0 +: DW] !== 64'hA3) begin failures++; $display("FAIL wrap_slot0: got %h expected a3", data_line_out[0 +: DW]); end
      checks++; if (data_line_out[4*DW +: DW] !== 64'hA7) begin failures++; $display("FAIL wrap_slot4: got %h expected a7", data_line_out[4*DW +: DW]); end
      tick(1);
      checks++; if (data_valid_out !== 1'b0) begin failures++; $display("FAIL wrap_pulse: got %b expected 0", data_valid_out); end
   endtask

   task automatic test_spacing();
      int t1, t2;
      for (int gap = 8; gap >= 4; gap -= 4) begin
         do_reset();
         tick(1);
         issue({$urandom, $urandom}, 3'($urandom_range(0, 7)), t1);
         tick(gap - 1);
         issue({$urandom, $urandom}, 3'($urandom_range(0, 7)), t2);
         wait_edge(last_done + 1);
         checks++;
         if (obs.size() != 2) begin failures++; $display("FAIL spacing%0d_lines: got %0d expected 2", gap, obs.size()); end
         else begin
            checks++; if (obs[1].e - obs[0].e !== BL) begin failures++; $display("FAIL spacing%0d_pulse_gap: got %0d expected %0d", gap, obs[1].e - obs[0].e, BL); end
            checks++; if (obs[1].e !== t1 + CAS + 2*BL - 1) begin failures++; $display("FAIL spacing%0d_second_edge: got %0d expected %0d", gap, obs[1].e, t1 + CAS + 2*BL - 1); end
            foreach (obs[j]) begin
               checks++;
               if ({obs[j].e, obs[j].tag, obs[j].line} !== {pend[j].done, pend[j].tag, line_of(pend[j])}) begin
                  failures++;
                  $display("FAIL spacing%0d_line%0d: got edge %0d tag %h line %h, expected edge %0d tag %h line %h", gap, j, obs[j].e, obs[j].tag, obs[j].line, pend[j].done, pend[j].tag, line_of(pend[j]));
               end
            end
         end
         checks++; if (timing_err_out !== (gap < BL)) begin failures++; $display("FAIL spacing%0d_timing_err: got %b expected %b", gap, timing_err_out, gap < BL); end
         checks++; if (timing_err_out !== terr_model()) begin failures++; $display("FAIL spacing%0d_timing_model: got %b expected %b", gap, timing_err_out, terr_model()); end
      end
   endtask

   task automatic test_full();
      int t;
      do_reset();
      tick(1);
      for (int k = 0; k < QD; k++) issue(64'h5000 + 64'(k), 3'(k), t);
      tick(1);
      checks++; if (count_out !== 5'd16) begin failures++; $display("FAIL full_count: got %0d expected 16", count_out); end
      checks++; if (issue_ready_out !== 1'b0) begin failures++; $display("FAIL full_ready: got %b expected 0", issue_ready_out); end
      checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL full_no_overflow: got %b expected 0", overflow_out); end
      issue(64'h6000, 3'd1, t);
      tick(1);
      checks++; if (overflow_out !== 1'b1) begin failures++; $display("FAIL full_overflow: got %b expected 1", overflow_out); end
      checks++; if (count_out !== 5'd16) begin failures++; $display("FAIL full_count_after: got %0d expected 16", count_out); end
      wait_edge(last_done + 1);
      checks++;
      if (obs.size() != QD || pend.size() != QD) begin failures++; $display("FAIL full_lines: got %0d expected %0d", obs.size(), QD); end
      else foreach (obs[j]) begin
         checks++;
         if ({obs[j].e, obs[j].tag, obs[j].line} !== {pend[j].done, pend[j].tag, line_of(pend[j])}) begin
            failures++;
            $display("FAIL full_line%0d: got edge %0d tag %h line %h, expected edge %0d tag %h line %h", j, obs[j].e, obs[j].tag, obs[j].line, pend[j].done, pend[j].tag, line_of(pend[j]));
         end
      end
   endtask

   task automatic test_flush();
      int t;
      do_reset();
      tick(1);
      issue(64'hF00D, 3'($urandom_range(0, 7)), t);
      wait_edge(t + CAS + 2);
      do_flush();
      tick(1);
      checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL flush_count: got %0d expected 0", count_out); end
      checks++; if (capturing_out !== 1'b0) begin failures++; $display("FAIL flush_capturing: got %b expected 0", capturing_out); end
      wait_edge(t + CAS + BL + 4);
      checks++; if (obs.size() != 0) begin failures++; $display("FAIL flush_no_valid: got %0d lines expected 0", obs.size()); end
      issue(64'h7777, 3'd6, t);
      wait_edge(last_done + 1);
      checks++;
      if (obs.size() != 1 || pend.size() != 1) begin failures++; $display("FAIL flush_fresh_lines: got %0d expected 1", obs.size()); end
      else if ({obs[0].e, obs[0].tag, obs[0].line} !== {pend[0].done, pend[0].tag, line_of(pend[0])}) begin
         failures++;
         $display("FAIL flush_fresh_line: got edge %0d tag %h line %h, expected edge %0d tag %h line %h", obs[0].e, obs[0].tag, obs[0].line, pend[0].done, pend[0].tag, line_of(pend[0]));
      end
      issue(64'hCAFE, 3'd2, t);
      wait_edge(t + CAS + 2);
      rst_in = 1'b1;
      #1;
      checks++; if (capturing_out !== 1'b0) begin failures++; $display("FAIL rstmid_capturing: got %b expected 0", capturing_out); end
      checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL rstmid_count: got %0d expected 0", count_out); end
      checks++; if (data_line_out !== '0) begin failures++; $display("FAIL rstmid_line: got %h expected 0", data_line_out); end
      checks++; if (data_tag_out !== '0) begin failures++; $display("FAIL rstmid_tag: got %h expected 0", data_tag_out); end
      tick(2);
      rst_in = 1'b0;
      pend.delete();
      obs.delete();
      last_done = -1000;
      exp_ovf = 1'b0;
      exp_terr = 1'b0;
      tick(CAS + 2*BL);
      checks++; if (obs.size() != 0) begin failures++; $display("FAIL rstmid_no_valid: got %0d lines expected 0", obs.size()); end
   endtask

   task automatic test_random();
      int t, r;
      do_reset();
      tick(1);
      repeat (150) begin
         r = $urandom_range(0, 19);
         if (r == 0) do_flush();
         else if (r < 12) issue({$urandom, $urandom}, 3'($urandom_range(0, 7)), t);
         tick($urandom_range(1, 9));
         checks++; if (count_out !== 5'(occ(edge_n))) begin failures++; $display("FAIL random_count@%0d: got %0d expected %0d", edge_n, count_out, occ(edge_n)); end
         checks++; if (overflow_out !== exp_ovf) begin failures++; $display("FAIL random_overflow@%0d: got %b expected %b", edge_n, overflow_out, exp_ovf); end
         checks++; if (timing_err_out !== terr_model()) begin failures++; $display("FAIL random_timing_err@%0d: got %b expected %b", edge_n, timing_err_out, terr_model()); end
      end
      wait_edge(last_done + 1);
      tick(2);
      checks++;
      if (obs.size() != pend.size()) begin failures++; $display("FAIL random_lines: got %0d expected %0d", obs.size(), pend.size()); end
      else foreach (obs[j]) begin
         checks++;
         if ({obs[j].e, obs[j].tag, obs[j].line} !== {pend[j].done, pend[j].tag, line_of(pend[j])}) begin
            failures++;
            $display("FAIL random_line%0d: got edge %0d tag %h line %h, expected edge %0d tag %h line %h", j, obs[j].e, obs[j].tag, obs[j].line, pend[j].done, pend[j].tag, line_of(pend[j]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_spacing();
      test_full();
      test_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
